// File: rtl/axi_lite_arbiter_2to1_if.sv
// AXI-lite channel bundle (aw/w/b/ar/r) shared by requesters and the target.
// Latency: none, pure wiring.
// Backpressure: carries plain valid/ready pairs on every channel.
interface axi_lite_arbiter_2to1_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [RESP_WIDTH-1:0]   bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [RESP_WIDTH-1:0]   rresp;
  logic                    rvalid;
  logic                    rready;

  // Issuer of transactions.
  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  // Responder to transactions.
  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_arbiter_2to1.sv
// Round-robin 2:1 AXI-lite arbiter, independent write and read paths, one outstanding each.
// Latency: request sampled -> upstream ready +1, target valid +2, target ready +3, reply +4.
// Backpressure: each phase holds its valid/ready until handshake; all outputs registered.
module axi_lite_arbiter_2to1 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  axi_lite_arbiter_2to1_if.slave  s0,
  axi_lite_arbiter_2to1_if.slave  s1,
  axi_lite_arbiter_2to1_if.master m0,
  output logic [1:0]             wr_grant,
  output logic [1:0]             rd_grant
);

  typedef enum logic [2:0] {W_IDLE, W_ACCEPT, W_ISSUE, W_RESP, W_REPLY} wr_state_t;
  typedef enum logic [2:0] {R_IDLE, R_ACCEPT, R_ISSUE, R_DATA, R_REPLY} rd_state_t;

  // Write path state
  wr_state_t               wr_state;
  logic                    wr_ptr;
  logic [1:0]              w_acc;
  logic                    m_awvalid, m_wvalid, m_bready;
  logic [ADDR_WIDTH-1:0]   m_awaddr;
  logic [DATA_WIDTH-1:0]   m_wdata;
  logic [DATA_WIDTH/8-1:0] m_wstrb;
  logic [RESP_WIDTH-1:0]   bresp_q;
  logic [1:0]              s_bvalid;

  // Read path state
  rd_state_t               rd_state;
  logic                    rd_ptr;
  logic [1:0]              r_acc;
  logic                    m_arvalid, m_rready;
  logic [ADDR_WIDTH-1:0]   m_araddr;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [RESP_WIDTH-1:0]   rresp_q;
  logic [1:0]              s_rvalid;

  // A write is only eligible once both address and data are offered together.
  logic w_elig0, w_elig1, w_pick, w_own, w_bready;
  logic r_elig0, r_elig1, r_pick, r_own, r_rready;

  assign w_elig0  = s0.awvalid & s0.wvalid;
  assign w_elig1  = s1.awvalid & s1.wvalid;
  assign w_pick   = (w_elig0 & w_elig1) ? wr_ptr : w_elig1;
  assign w_own    = wr_grant[1];
  assign w_bready = w_own ? s1.bready : s0.bready;

  assign r_elig0  = s0.arvalid;
  assign r_elig1  = s1.arvalid;
  assign r_pick   = (r_elig0 & r_elig1) ? rd_ptr : r_elig1;
  assign r_own    = rd_grant[1];
  assign r_rready = r_own ? s1.rready : s0.rready;

  // Write FSM: grant, accept, issue aw/w independently, collect b, reply to owner.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_state  <= W_IDLE;
      wr_ptr    <= 1'b0;
      wr_grant  <= 2'b00;
      w_acc     <= 2'b00;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_awaddr  <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      bresp_q   <= '0;
      s_bvalid  <= 2'b00;
    end else begin
      case (wr_state)
        W_IDLE: if (w_elig0 | w_elig1) begin
          wr_grant <= w_pick ? 2'b10 : 2'b01;
          w_acc    <= w_pick ? 2'b10 : 2'b01;
          wr_state <= W_ACCEPT;
        end
        W_ACCEPT: begin
          w_acc     <= 2'b00;
          m_awaddr  <= w_own ? s1.awaddr : s0.awaddr;
          m_wdata   <= w_own ? s1.wdata  : s0.wdata;
          m_wstrb   <= w_own ? s1.wstrb  : s0.wstrb;
          m_awvalid <= 1'b1;
          m_wvalid  <= 1'b1;
          wr_state  <= W_ISSUE;
        end
        W_ISSUE: begin
          if (m0.awready) m_awvalid <= 1'b0;
          if (m0.wready)  m_wvalid  <= 1'b0;
          if ((!m_awvalid || m0.awready) && (!m_wvalid || m0.wready)) begin
            m_bready <= 1'b1;
            wr_state <= W_RESP;
          end
        end
        W_RESP: if (m0.bvalid) begin
          bresp_q  <= m0.bresp;
          m_bready <= 1'b0;
          s_bvalid <= wr_grant;
          wr_state <= W_REPLY;
        end
        W_REPLY: if (w_bready) begin
          s_bvalid <= 2'b00;
          wr_ptr   <= ~w_own;
          wr_grant <= 2'b00;
          wr_state <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: same shape as the write path with a single address channel.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rd_state  <= R_IDLE;
      rd_ptr    <= 1'b0;
      rd_grant  <= 2'b00;
      r_acc     <= 2'b00;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      m_araddr  <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      s_rvalid  <= 2'b00;
    end else begin
      case (rd_state)
        R_IDLE: if (r_elig0 | r_elig1) begin
          rd_grant <= r_pick ? 2'b10 : 2'b01;
          r_acc    <= r_pick ? 2'b10 : 2'b01;
          rd_state <= R_ACCEPT;
        end
        R_ACCEPT: begin
          r_acc     <= 2'b00;
          m_araddr  <= r_own ? s1.araddr : s0.araddr;
          m_arvalid <= 1'b1;
          rd_state  <= R_ISSUE;
        end
        R_ISSUE: if (m0.arready) begin
          m_arvalid <= 1'b0;
          m_rready  <= 1'b1;
          rd_state  <= R_DATA;
        end
        R_DATA: if (m0.rvalid) begin
          rdata_q  <= m0.rdata;
          rresp_q  <= m0.rresp;
          m_rready <= 1'b0;
          s_rvalid <= rd_grant;
          rd_state <= R_REPLY;
        end
        R_REPLY: if (r_rready) begin
          s_rvalid <= 2'b00;
          rd_ptr   <= ~r_own;
          rd_grant <= 2'b00;
          rd_state <= R_IDLE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Both requesters see the same captured response; only the owner gets valid.
  assign s0.awready = w_acc[0];
  assign s0.wready  = w_acc[0];
  assign s1.awready = w_acc[1];
  assign s1.wready  = w_acc[1];
  assign s0.bvalid  = s_bvalid[0];
  assign s1.bvalid  = s_bvalid[1];
  assign s0.bresp   = bresp_q;
  assign s1.bresp   = bresp_q;
  assign s0.arready = r_acc[0];
  assign s1.arready = r_acc[1];
  assign s0.rvalid  = s_rvalid[0];
  assign s1.rvalid  = s_rvalid[1];
  assign s0.rdata   = rdata_q;
  assign s1.rdata   = rdata_q;
  assign s0.rresp   = rresp_q;
  assign s1.rresp   = rresp_q;

  assign m0.awaddr  = m_awaddr;
  assign m0.awvalid = m_awvalid;
  assign m0.wdata   = m_wdata;
  assign m0.wstrb   = m_wstrb;
  assign m0.wvalid  = m_wvalid;
  assign m0.bready  = m_bready;
  assign m0.araddr  = m_araddr;
  assign m0.arvalid = m_arvalid;
  assign m0.rready  = m_rready;

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
module tb_axi_lite_arbiter_2to1;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RW = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] wr_grant, rd_grant;
  int         total = 0;
  int         bad = 0;
  int         n0, n1, w;

  axi_lite_arbiter_2to1_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) s0_if ();
  axi_lite_arbiter_2to1_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) s1_if ();
  axi_lite_arbiter_2to1_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) m0_if ();

  axi_lite_arbiter_2to1 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) dut (
    .axi_aclk   (clk),
    .axi_aresetn(rst_n),
    .s0         (s0_if),
    .s1         (s1_if),
    .m0         (m0_if),
    .wr_grant   (wr_grant),
    .rd_grant   (rd_grant)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_wr(input int n, input logic v, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] st);
    if (n == 0) begin
      s0_if.awvalid = v; s0_if.wvalid = v; s0_if.awaddr = a; s0_if.wdata = d; s0_if.wstrb = st;
    end else begin
      s1_if.awvalid = v; s1_if.wvalid = v; s1_if.awaddr = a; s1_if.wdata = d; s1_if.wstrb = st;
    end
  endtask

  task automatic set_rd(input int n, input logic v, input logic [7:0] a);
    if (n == 0) begin
      s0_if.arvalid = v; s0_if.araddr = a;
    end else begin
      s1_if.arvalid = v; s1_if.araddr = a;
    end
  endtask

  task automatic defaults;
    set_wr(0, 1'b0, 8'h00, 32'h0, 4'h0);
    set_wr(1, 1'b0, 8'h00, 32'h0, 4'h0);
    set_rd(0, 1'b0, 8'h00);
    set_rd(1, 1'b0, 8'h00);
    s0_if.bready = 1'b1; s0_if.rready = 1'b1;
    s1_if.bready = 1'b1; s1_if.rready = 1'b1;
    m0_if.awready = 1'b1; m0_if.wready = 1'b1; m0_if.arready = 1'b1;
    m0_if.bvalid = 1'b1;  m0_if.bresp = 3'd0;
    m0_if.rvalid = 1'b1;  m0_if.rresp = 3'd0; m0_if.rdata = 32'h0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    defaults;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst wr_grant", wr_grant, 0);
    chk("rst rd_grant", rd_grant, 0);
    chk("rst s0 awready", s0_if.awready, 0);
    chk("rst m0 awvalid", m0_if.awvalid, 0);
    chk("rst m0 bready", m0_if.bready, 0);
    chk("rst s0 bvalid", s0_if.bvalid, 0);
    chk("rst m0 awaddr", m0_if.awaddr, 0);
    tick;
    rst_n = 1'b1;

    // 1: single zero-wait write from s0
    set_wr(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF);
    tick;
    chk("t1 grant", wr_grant, 2'b01);
    chk("t1 s0 awready", s0_if.awready, 1);
    chk("t1 s0 wready", s0_if.wready, 1);
    chk("t1 s1 awready", s1_if.awready, 0);
    chk("t1 m0 awvalid early", m0_if.awvalid, 0);
    tick;
    set_wr(0, 1'b0, 8'h00, 32'h0, 4'h0);
    chk("t1 m0 awvalid", m0_if.awvalid, 1);
    chk("t1 m0 wvalid", m0_if.wvalid, 1);
    chk("t1 m0 awaddr", m0_if.awaddr, 32'h04);
    chk("t1 m0 wdata", m0_if.wdata, 32'hDEADBEEF);
    chk("t1 m0 wstrb", m0_if.wstrb, 32'hF);
    chk("t1 s0 awready drop", s0_if.awready, 0);
    chk("t1 m0 bready early", m0_if.bready, 0);
    tick;
    chk("t1 m0 awvalid drop", m0_if.awvalid, 0);
    chk("t1 m0 bready", m0_if.bready, 1);
    chk("t1 s0 bvalid early", s0_if.bvalid, 0);
    tick;
    chk("t1 s0 bvalid", s0_if.bvalid, 1);
    chk("t1 s0 bresp", s0_if.bresp, 0);
    chk("t1 m0 bready drop", m0_if.bready, 0);
    chk("t1 grant hold", wr_grant, 2'b01);
    tick;
    chk("t1 s0 bvalid drop", s0_if.bvalid, 0);
    chk("t1 grant idle", wr_grant, 0);

    // 2: both requesters continuously eligible, grants alternate from s0
    do_reset;
    n0 = 0;
    n1 = 0;
    set_wr(0, 1'b1, 8'h20, 32'hA0000000, 4'h3);
    set_wr(1, 1'b1, 8'h40, 32'hB0000000, 4'hC);
    for (int k = 0; k < 4; k++) begin
      w = k % 2;
      tick;
      chk("t2 grant", wr_grant, (w == 1) ? 2'b10 : 2'b01);
      chk("t2 loser awready", (w == 1) ? s0_if.awready : s1_if.awready, 0);
      tick;
      chk("t2 m0 awaddr", m0_if.awaddr, (w == 1) ? 32'h40 + n1 : 32'h20 + n0);
      chk("t2 m0 wdata", m0_if.wdata, (w == 1) ? 32'hB0000000 + n1 : 32'hA0000000 + n0);
      chk("t2 m0 wstrb", m0_if.wstrb, (w == 1) ? 32'hC : 32'h3);
      if (w == 1) begin
        n1++;
        set_wr(1, 1'b1, 8'h40 + 8'(n1), 32'hB0000000 + n1, 4'hC);
      end else begin
        n0++;
        set_wr(0, 1'b1, 8'h20 + 8'(n0), 32'hA0000000 + n0, 4'h3);
      end
      tick;
      tick;
      chk("t2 winner bvalid", (w == 1) ? s1_if.bvalid : s0_if.bvalid, 1);
      chk("t2 loser bvalid", (w == 1) ? s0_if.bvalid : s1_if.bvalid, 0);
      tick;
      chk("t2 idle", wr_grant, 0);
    end
    set_wr(0, 1'b0, 8'h00, 32'h0, 4'h0);
    set_wr(1, 1'b0, 8'h00, 32'h0, 4'h0);

    // 3: target delays awready by 3 cycles and wready by 1 cycle
    m0_if.awready = 1'b0;
    m0_if.wready  = 1'b0;
    set_wr(0, 1'b1, 8'h30, 32'h0000CAFE, 4'h1);
    tick;
    tick;
    set_wr(0, 1'b0, 8'h00, 32'h0, 4'h0);
    chk("t3 c2 awvalid", m0_if.awvalid, 1);
    chk("t3 c2 wvalid", m0_if.wvalid, 1);
    tick;
    chk("t3 c3 awvalid", m0_if.awvalid, 1);
    chk("t3 c3 wvalid", m0_if.wvalid, 1);
    m0_if.wready = 1'b1;
    tick;
    m0_if.wready = 1'b0;
    chk("t3 c4 awvalid", m0_if.awvalid, 1);
    chk("t3 c4 wvalid", m0_if.wvalid, 0);
    chk("t3 c4 bready", m0_if.bready, 0);
    tick;
    chk("t3 c5 awvalid", m0_if.awvalid, 1);
    chk("t3 c5 bready", m0_if.bready, 0);
    m0_if.awready = 1'b1;
    tick;
    m0_if.wready = 1'b1;
    chk("t3 c6 awvalid", m0_if.awvalid, 0);
    chk("t3 c6 bready", m0_if.bready, 1);
    chk("t3 m0 awaddr", m0_if.awaddr, 32'h30);
    tick;
    chk("t3 s0 bvalid", s0_if.bvalid, 1);
    tick;
    chk("t3 idle", wr_grant, 0);

    // 4: concurrent s0 write and s1 read
    m0_if.rdata = 32'h12345678;
    m0_if.rresp = 3'd2;
    set_wr(0, 1'b1, 8'h10, 32'h55AA55AA, 4'hF);
    set_rd(1, 1'b1, 8'h18);
    tick;
    chk("t4 wr_grant", wr_grant, 2'b01);
    chk("t4 rd_grant", rd_grant, 2'b10);
    chk("t4 s1 arready", s1_if.arready, 1);
    chk("t4 s0 arready", s0_if.arready, 0);
    tick;
    set_wr(0, 1'b0, 8'h00, 32'h0, 4'h0);
    set_rd(1, 1'b0, 8'h00);
    chk("t4 m0 arvalid", m0_if.arvalid, 1);
    chk("t4 m0 araddr", m0_if.araddr, 32'h18);
    chk("t4 m0 awaddr", m0_if.awaddr, 32'h10);
    tick;
    chk("t4 m0 arvalid drop", m0_if.arvalid, 0);
    chk("t4 m0 rready", m0_if.rready, 1);
    tick;
    chk("t4 s1 rvalid", s1_if.rvalid, 1);
    chk("t4 s1 rdata", s1_if.rdata, 32'h12345678);
    chk("t4 s1 rresp", s1_if.rresp, 2);
    chk("t4 s0 rvalid", s0_if.rvalid, 0);
    chk("t4 s0 bvalid", s0_if.bvalid, 1);
    tick;
    chk("t4 s1 rvalid drop", s1_if.rvalid, 0);
    chk("t4 rd idle", rd_grant, 0);
    chk("t4 wr idle", wr_grant, 0);

    // 5: s0 stalls its response for 5 cycles while s1 waits
    m0_if.bresp = 3'd5;
    s0_if.bready = 1'b0;
    set_wr(0, 1'b1, 8'h50, 32'h00005050, 4'hF);
    tick;
    tick;
    set_wr(0, 1'b0, 8'h00, 32'h0, 4'h0);
    set_wr(1, 1'b1, 8'h60, 32'h00006060, 4'h5);
    tick;
    tick;
    chk("t5 s0 bvalid", s0_if.bvalid, 1);
    chk("t5 s0 bresp", s0_if.bresp, 5);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("t5 hold bvalid", s0_if.bvalid, 1);
      chk("t5 hold bresp", s0_if.bresp, 5);
      chk("t5 s1 blocked", s1_if.awready, 0);
      chk("t5 hold grant", wr_grant, 2'b01);
    end
    s0_if.bready = 1'b1;
    tick;
    chk("t5 s0 bvalid drop", s0_if.bvalid, 0);
    chk("t5 grant idle", wr_grant, 0);
    chk("t5 s1 not yet", s1_if.awready, 0);
    tick;
    chk("t5 s1 grant", wr_grant, 2'b10);
    chk("t5 s1 awready", s1_if.awready, 1);
    tick;
    set_wr(1, 1'b0, 8'h00, 32'h0, 4'h0);
    chk("t5 m0 awaddr", m0_if.awaddr, 32'h60);
    chk("t5 m0 wstrb", m0_if.wstrb, 32'h5);
    tick;
    tick;
    chk("t5 s1 bvalid", s1_if.bvalid, 1);
    chk("t5 s1 bresp", s1_if.bresp, 5);
    tick;
    chk("t5 idle", wr_grant, 0);
    m0_if.bresp = 3'd0;

    // 6: reset asserted in the issue phase, then simultaneous requests
    m0_if.awready = 1'b0;
    set_wr(0, 1'b1, 8'h70, 32'h00007070, 4'hF);
    tick;
    tick;
    set_wr(0, 1'b0, 8'h00, 32'h0, 4'h0);
    chk("t6 issue awvalid", m0_if.awvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6 rst awvalid", m0_if.awvalid, 0);
    chk("t6 rst wvalid", m0_if.wvalid, 0);
    chk("t6 rst wr_grant", wr_grant, 0);
    chk("t6 rst rd_grant", rd_grant, 0);
    chk("t6 rst s0 bvalid", s0_if.bvalid, 0);
    tick;
    tick;
    rst_n = 1'b1;
    m0_if.awready = 1'b1;
    set_wr(0, 1'b1, 8'h01, 32'h1, 4'hF);
    set_wr(1, 1'b1, 8'h02, 32'h2, 4'hF);
    set_rd(0, 1'b1, 8'h03);
    set_rd(1, 1'b1, 8'h04);
    tick;
    chk("t6 wr_grant s0", wr_grant, 2'b01);
    chk("t6 rd_grant s0", rd_grant, 2'b01);
    chk("t6 s1 awready", s1_if.awready, 0);
    chk("t6 s1 arready", s1_if.arready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_lite_arbiter_2to1.md
Name: axi_lite_arbiter_2to1

Overview:
- Two-requester to one-target AXI-lite arbiter.
- Shares a single downstream AXI-lite slave (for example, one of the bus master ports) between two upstream masters s0 and s1.
- Write and read paths are arbitrated independently, each with its own round-robin pointer.
- One outstanding transaction per path; all payloads are registered.

Parameters:
DATA_WIDTH, 32, data bus width in bits; a multiple of 8.
ADDR_WIDTH, 8, address width in bits.
RESP_WIDTH, 3, bresp/rresp width in bits.

Ports:
axi_aclk  input  1  single clock; all logic on its rising edge.
axi_aresetn  input  1  asynchronous, active-low reset.
sN_axi_awaddr/awvalid in ADDR_WIDTH/1; sN_axi_awready out 1  (N=0,1) write address from requester N.
sN_axi_wdata/wstrb/wvalid in DATA_WIDTH/DATA_WIDTH/8/1; sN_axi_wready out 1  write data from requester N.
sN_axi_bresp/bvalid out RESP_WIDTH/1; sN_axi_bready in 1  write response to requester N.
sN_axi_araddr/arvalid in ADDR_WIDTH/1; sN_axi_arready out 1  read address from requester N.
sN_axi_rdata/rresp/rvalid out DATA_WIDTH/RESP_WIDTH/1; sN_axi_rready in 1  read data to requester N.
m0_axi_awaddr/awvalid out; m0_axi_awready in  write address to target.
m0_axi_wdata/wstrb/wvalid out; m0_axi_wready in  write data to target.
m0_axi_bresp/bvalid in; m0_axi_bready out  write response from target.
m0_axi_araddr/arvalid out; m0_axi_arready in  read address to target.
m0_axi_rdata/rresp/rvalid in; m0_axi_rready out  read data from target.
wr_grant  output  2  one-hot owner of the write path; 0 when idle.
rd_grant  output  2  one-hot owner of the read path; 0 when idle.

Behaviour:
- Reset (async, axi_aresetn=0):
  - Both FSMs go to IDLE.
  - All ready/valid outputs, payload registers, wr_grant and rd_grant are 0.
  - Both round-robin pointers are 0 (s0 has priority).
- All outputs are registered; there are no combinational paths from input to output.
- Write FSM states: W_IDLE, W_ACCEPT, W_ISSUE, W_RESP, W_REPLY.
- W_IDLE:
  - Requester N is eligible when sN_awvalid && sN_wvalid. awvalid without wvalid, or the reverse, is not eligible.
  - If only one requester is eligible, it wins.
  - If both are eligible, the requester named by wr_ptr wins.
  - On a win: wr_grant is set one-hot and the FSM moves to W_ACCEPT.
- W_ACCEPT (exactly 1 cycle):
  - sN_awready and sN_wready are both 1.
  - awaddr, wdata and wstrb are captured at the exiting edge.
  - Go to W_ISSUE with m0_awvalid=m0_wvalid=1.
- W_ISSUE:
  - Each of m0_awvalid and m0_wvalid drops independently on its own handshake; the two may complete in either order or in the same cycle.
  - When both are done, go to W_RESP.
- W_RESP:
  - m0_bready=1.
  - On m0_bvalid, capture bresp unchanged (errors pass through) and go to W_REPLY.
- W_REPLY:
  - sN_bvalid=1 with the captured bresp, held until sN_bready.
  - Then: wr_ptr = the other requester, wr_grant=0, back to W_IDLE.
- Read FSM states: R_IDLE, R_ACCEPT, R_ISSUE, R_DATA, R_REPLY. It mirrors the write FSM:
  - Eligibility is sN_arvalid.
  - R_ACCEPT asserts sN_arready for 1 cycle.
  - R_ISSUE holds m0_arvalid until m0_arready.
  - R_DATA holds m0_rready until m0_rvalid, capturing rdata and rresp.
  - R_REPLY holds sN_rvalid until sN_rready; rd_ptr toggles on exit.
- Minimum latency with zero-wait target and requester:
  - Valid sampled at edge 0 -> sN_ready at cycle 1 -> m0 valids at cycle 2 -> m0_bready/m0_rready at cycle 3 -> sN_bvalid/rvalid at cycle 4.
  - Next grant is possible 1 cycle after the reply handshake.
- Independence of paths:
  - Read and write may be in flight concurrently, including for the same requester or different requesters.
  - The target handles read/write ordering.
- Non-granted requester: its ready outputs and its bvalid/rvalid stay 0.
- m0 responses arriving outside RESP/DATA are not accepted, because bready/rready are 0 there.
- Starvation: with both requesters continuously eligible, grants strictly alternate.
- Reset mid-transaction: the in-flight transaction is abandoned and all valids drop immediately. Upstream and target must also be reset.
- A requester dropping valid before ready (an AXI violation) is not supported.

Test Plan:
1. s0 alone writes awaddr=0x04, wdata=0xDEADBEEF, wstrb=0xF; target is zero-wait with bresp=0 -> m0 sees identical payload at cycle 2; s0_bvalid=1, bresp=0 at cycle 4; wr_grant=01 throughout, then 00.
2. s0 and s1 both assert write in the same cycle, held for 4 transactions -> grant order s0, s1, s0, s1 (pointer starts at 0); each target write carries its own requester's payload.
3. Target delays m0_awready by 3 cycles and m0_wready by 1 cycle -> awvalid and wvalid each drop on their own handshake; the FSM enters W_RESP only after both have completed.
4. s1 reads araddr=0x18 while s0 writes 0x10 in the same cycle; target returns rdata=0x12345678, rresp=2 -> both complete concurrently; s1 receives rdata=0x12345678, rresp=2 unchanged.
5. s0 holds sN_bready=0 for 5 cycles -> s0_bvalid and bresp stay stable; a pending s1 write is not accepted until the s0 reply handshake completes.
6. Assert axi_aresetn=0 during W_ISSUE -> all valid/ready/grant outputs are 0 immediately, without a clock edge; after release, the first simultaneous request is granted to s0.
